eta_sampler_arbiter: RTL and testbench
======================================

// Module: eta_sampler_arbiter
// PURPOSE
//  Shares one poly_uniform_eta sampler core between two requesters, e.g. the s1 (L=5) and s2 (K=6) vector generators in keygen.
//  Each request asks for a run of COUNT polynomials from one 512-bit seed with consecutive nonces.
//  The block arbitrates whole runs round-robin, sequences the sampler start/done handshake and streams each polynomial out through a one-entry valid/ready buffer.
// PARAMETERS
//  CNT_W    4    width of per-request polynomial count (max run = 2**CNT_W-1)
//  NONCE_W  16   nonce width
// PORTS
//  clock        in   1          rising-edge clock
//  reset        in   1          asynchronous, active-high reset
//  req_valid    in   2          per-requester request; level, held until matching req_done
//  req_seed     in   2*512      seed of requester r at [512*r+511:512*r]
//  req_nonce    in   2*NONCE_W  base nonce of requester r
//  req_count    in   2*CNT_W    polynomials requested by r
//  req_done     out  2          one-cycle pulse: run of requester r completed
//  smp_start    out  1          sampler start, level
//  smp_seed     out  512        seed to sampler
//  smp_nonce    out  NONCE_W    nonce to sampler
//  smp_poly     in   8192       sampler result (256 x 32-bit signed coeffs)
//  smp_done     in   1          sampler result valid
//  out_valid    out  1          out_poly holds a polynomial
//  out_ready    in   1          consumer accepts when out_valid & out_ready
//  out_poly     out  8192       buffered polynomial
//  out_id       out  1          requester owning out_poly
//  out_idx      out  CNT_W      poly index within the run (0..count-1)
// BEHAVIOUR
//  Reset (async): state=IDLE; smp_start, out_valid, req_done = 0; rr pointer=0; out_idx=0; buffer contents don't-care.
//  States: IDLE, ARB, START, WAIT, HOLD, FIN.
//  IDLE: if any req_valid -> ARB next cycle.
//  ARB: only one valid -> grant it; both valid -> grant rr pointer, then rr flips to the other. Latch granted
//   seed, nonce base, count, id into internal regs; cnt=0. count==0 -> FIN (no sampler use). Else -> START.
//  START: smp_start=1, smp_seed/smp_nonce = latched seed, base+cnt (mod 2**NONCE_W, wraps) -> WAIT.
//  WAIT: smp_start held 1 until smp_done sampled high. On smp_done: capture smp_poly to buffer,
//   out_valid=1, out_id=grant, out_idx=cnt; smp_start=0 from that cycle -> HOLD.
//  HOLD: wait for out_valid & out_ready (transfer); out_valid=0 next cycle; cnt+1.
//   If cnt+1 < count -> START, else -> FIN. smp_start stays 0 in HOLD: at least one low cycle between runs.
//  FIN: req_done[grant]=1 for exactly one cycle -> IDLE. The requester must drop req_valid within 1 cycle
//   of req_done; a request still high in IDLE is treated as a new run.
//  Latency: req_valid rising in IDLE -> smp_start high 3 cycles later (IDLE, ARB, START).
//   smp_done -> out_valid next edge.
//  req_seed/nonce/count may change after grant; the latched copies are used for the whole run.
//  req_valid dropped mid-run is ignored; the run completes.
//  Out buffer is one entry; no sampler start while out_valid=1.
//  smp_done outside WAIT is ignored.
//  Simultaneous request from the loser during a run: served next, so there is no starvation.
//  Reset mid-run aborts: no req_done, buffer discarded. The sampler shares the same reset.
// TESTING
//  1. Req0 count=5 nonce=0, sampler model done after 20 cycles ->
//     5 polys out_id=0, idx 0..4, nonces 0..4, one req_done[0] pulse.
//  2. Req0 cnt=5 base 0 and req1 cnt=6 base 5 asserted same cycle after reset ->
//     req0 run first (rr=0), then req1, nonces 5..10; a second tie grants req1 first.
//  3. out_ready held 0 for 50 cycles after first poly -> out_poly/out_idx stable,
//     smp_start stays 0, no data loss.
//  4. count=0 on req1 -> req_done[1] pulses 2 cycles after request, smp_start never rises.
//  5. base nonce 0xFFFE, count=3 -> smp_nonce 0xFFFE, 0xFFFF, 0x0000.
//  6. Assert reset during WAIT of poly 2 -> outputs at reset values immediately,
//     no req_done, a fresh request restarts at idx 0.

Source files
------------

// File: rtl/eta_sampler_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : eta_sampler_arbiter_if
// Brief   : Bundles the request, sampler and output-stream signals of
//           eta_sampler_arbiter. The master view is the arbiter itself and
//           the slave view is its surroundings.
// Revision: 1.0 - initial release
// ============================================================================
interface eta_sampler_arbiter_if #(
  parameter int CNT_W   = 4,
  parameter int NONCE_W = 16
);
  // requester side
  logic [1:0]           req_valid;
  logic [1023:0]        req_seed;
  logic [2*NONCE_W-1:0] req_nonce;
  logic [2*CNT_W-1:0]   req_count;
  logic [1:0]           req_done;
  // sampler side
  logic                 smp_start;
  logic [511:0]         smp_seed;
  logic [NONCE_W-1:0]   smp_nonce;
  logic [8191:0]        smp_poly;
  logic                 smp_done;
  // output stream
  logic                 out_valid;
  logic                 out_ready;
  logic [8191:0]        out_poly;
  logic                 out_id;
  logic [CNT_W-1:0]     out_idx;

  modport master (
    input  req_valid, req_seed, req_nonce, req_count, smp_poly, smp_done, out_ready,
    output req_done, smp_start, smp_seed, smp_nonce, out_valid, out_poly, out_id, out_idx
  );

  modport slave (
    output req_valid, req_seed, req_nonce, req_count, smp_poly, smp_done, out_ready,
    input  req_done, smp_start, smp_seed, smp_nonce, out_valid, out_poly, out_id, out_idx
  );
endinterface
`default_nettype wire

// File: rtl/eta_sampler_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : eta_sampler_arbiter
// Brief   : Shares one poly_uniform_eta sampler between two requesters.
//           Whole runs of consecutive-nonce polynomials are granted
//           round-robin; each result streams out via a one-entry buffer.
// Revision: 1.0 - initial release
// ============================================================================
module eta_sampler_arbiter #(
  parameter int CNT_W   = 4,
  parameter int NONCE_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  eta_sampler_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARB   = 3'd1,
    START = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4,
    FIN   = 3'd5
  } state_t;

  state_t             state;
  logic               rr;
  logic               grant;
  logic [511:0]       seed_q;
  logic [NONCE_W-1:0] base_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   cnt;
  logic               smp_start_q;
  logic               out_valid_q;
  logic               out_id_q;
  logic [CNT_W-1:0]   out_idx_q;
  logic [8191:0]      out_poly_q;
  logic [1:0]         req_done_q;

  logic               pick;
  logic [CNT_W-1:0]   pick_count;
  logic [NONCE_W-1:0] pick_nonce;
  logic [CNT_W:0]     cnt_next;

  // Requester chosen in ARB: the only one asking, or the round-robin pointer on a tie
  always_comb begin
    pick = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      pick = rr;
    end
    pick_count = pick ? bus.req_count[2*CNT_W-1:CNT_W] : bus.req_count[CNT_W-1:0];
    pick_nonce = pick ? bus.req_nonce[2*NONCE_W-1:NONCE_W] : bus.req_nonce[NONCE_W-1:0];
  end

  // One extra bit so the run-length compare cannot wrap at the maximum count
  assign cnt_next = {1'b0, cnt} + 1'b1;

  // Run sequencer: arbitration, sampler handshake, output buffer valid and done pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rr          <= 1'b0;
      grant       <= 1'b0;
      base_q      <= '0;
      count_q     <= '0;
      cnt         <= '0;
      smp_start_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_idx_q   <= '0;
      req_done_q  <= '0;
    end else begin
      req_done_q <= '0;
      case (state)
        IDLE: begin
          if (|bus.req_valid) begin
            state <= ARB;
          end
        end
        ARB: begin
          if (|bus.req_valid) begin
            grant   <= pick;
            base_q  <= pick_nonce;
            count_q <= pick_count;
            cnt     <= '0;
            if (bus.req_valid == 2'b11) begin
              rr <= ~pick;
            end
            if (pick_count == '0) begin
              req_done_q[pick] <= 1'b1;
              state            <= FIN;
            end else begin
              state <= START;
            end
          end else begin
            state <= IDLE;
          end
        end
        START: begin
          smp_start_q <= 1'b1;
          state       <= WAIT;
        end
        WAIT: begin
          if (bus.smp_done) begin
            smp_start_q <= 1'b0;
            out_valid_q <= 1'b1;
            out_id_q    <= grant;
            out_idx_q   <= cnt;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            cnt         <= cnt_next[CNT_W-1:0];
            if (cnt_next < {1'b0, count_q}) begin
              state <= START;
            end else begin
              req_done_q[grant] <= 1'b1;
              state             <= FIN;
            end
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Wide datapath registers carry no reset; their content is qualified by the FSM
  always_ff @(posedge clock) begin
    if (state == ARB && (|bus.req_valid)) begin
      seed_q <= pick ? bus.req_seed[1023:512] : bus.req_seed[511:0];
    end
    if (state == WAIT && bus.smp_done) begin
      out_poly_q <= bus.smp_poly;
    end
  end

  assign bus.smp_start = smp_start_q;
  assign bus.smp_seed  = seed_q;
  assign bus.smp_nonce = base_q + {{(NONCE_W-CNT_W){1'b0}}, cnt};
  assign bus.out_valid = out_valid_q;
  assign bus.out_poly  = out_poly_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.req_done  = req_done_q;

endmodule
`default_nettype wire

// File: tb/tb_eta_sampler_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_eta_sampler_arbiter
// Brief   : Scoreboard bench for eta_sampler_arbiter with a sampler model,
//           per-requester expected-polynomial queues and directed plus
//           randomized runs.
// Revision: 1.0 - initial release
// ============================================================================
module tb_eta_sampler_arbiter;
  localparam int CNT_W   = 4;
  localparam int NONCE_W = 16;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  eta_sampler_arbiter_if #(.CNT_W(CNT_W), .NONCE_W(NONCE_W)) bus ();

  eta_sampler_arbiter #(.CNT_W(CNT_W), .NONCE_W(NONCE_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [CNT_W-1:0] idx;
    logic [8191:0]    poly;
  } exp_t;

  exp_t         q0[$];
  exp_t         q1[$];
  int           runs_pend[2];
  bit           got_first[2];
  int           done_order[$];
  logic [15:0]  nonce_log[$];
  int           total = 0;
  int           bad = 0;
  int           start_count = 0;
  int           smp_lat = 20;
  int           ready_mode = 0;
  int           stall = 0;
  bit           stall_arm = 0;
  bit           hold_prev = 0;
  logic [8191:0]    prev_poly;
  logic [CNT_W-1:0] prev_idx;
  logic             prev_id;

  // Sampler result as a pure function of seed and nonce
  function automatic logic [8191:0] poly_of(input logic [511:0] s, input logic [15:0] n);
    logic [8191:0] p;
    for (int k = 0; k < 256; k++) begin
      p[k*32 +: 32] = s[(k % 16)*32 +: 32] ^ {n, 8'(k), 8'hA5};
    end
    return p;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] v;
    for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic chk_poly(input string name, input logic [8191:0] act, input logic [8191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual[63:0]=%h required[63:0]=%h", name, act[63:0], req[63:0]);
    end
  endtask

  // One clock step for the stimulus thread: requesters drop on done and scramble after grant
  task automatic tick();
    @(posedge clock);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (bus.req_done[r]) begin
        bus.req_valid[r] = 1'b0;
      end else if (got_first[r] && bus.req_valid[r]) begin
        bus.req_seed[512*r +: 512] = rand512();
        bus.req_nonce[16*r +: 16]  = 16'($urandom());
        bus.req_count[4*r +: 4]    = 4'($urandom());
      end
    end
  endtask

  // Issue a request and push the run it must produce, derived from nonce = base + idx
  task automatic issue(input int r, input logic [511:0] seed, input logic [15:0] base,
                       input logic [3:0] cnt);
    exp_t e;
    for (int i = 0; i < int'(cnt); i++) begin
      e.idx  = CNT_W'(i);
      e.poly = poly_of(seed, base + 16'(i));
      if (r == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
    runs_pend[r]++;
    bus.req_seed[512*r +: 512] = seed;
    bus.req_nonce[16*r +: 16]  = base;
    bus.req_count[4*r +: 4]    = cnt;
    bus.req_valid[r]           = 1'b1;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    while ((runs_pend[0] != 0 || runs_pend[1] != 0) && n < budget) begin
      tick();
      n++;
    end
    total++;
    if (n >= budget) begin
      bad++;
      $display("FAIL %s_timeout pending0=%0d pending1=%0d required 0", name, runs_pend[0], runs_pend[1]);
    end
    chk({name, "_q0_empty"}, 64'(q0.size()), 64'd0);
    chk({name, "_q1_empty"}, 64'(q1.size()), 64'd0);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    q0.delete();
    q1.delete();
    runs_pend[0] = 0;
    runs_pend[1] = 0;
    got_first[0] = 0;
    got_first[1] = 0;
    bus.req_valid = 2'b00;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Sampler model: start level in, done pulse after a latency, logs every nonce it is given
  initial begin : sampler
    bit               busy = 0;
    int               left = 0;
    logic [511:0]     seed_c;
    logic [15:0]      nonce_c;
    bus.smp_done = 1'b0;
    bus.smp_poly = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset) begin
        busy = 0;
        bus.smp_done = 1'b0;
      end else if (bus.smp_done) begin
        bus.smp_done = 1'b0;
        chk("done_to_out_valid", 64'(bus.out_valid), 64'd1);
      end else if (busy) begin
        if (left == 0) begin
          bus.smp_done = 1'b1;
          bus.smp_poly = poly_of(seed_c, nonce_c);
          busy = 0;
        end else begin
          left--;
        end
      end else if (bus.smp_start) begin
        busy    = 1;
        seed_c  = bus.smp_seed;
        nonce_c = bus.smp_nonce;
        left    = smp_lat;
        start_count++;
        nonce_log.push_back(nonce_c);
        chk("start_with_buffer_empty", 64'(bus.out_valid), 64'd0);
      end
    end
  end

  // Consumer: always ready, random ready, or a 50-cycle stall after the next poly
  initial begin : consumer
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (stall_arm && bus.out_valid) begin
        stall = 50;
        stall_arm = 0;
      end
      if (stall > 0) begin
        bus.out_ready = 1'b0;
        stall--;
      end else if (ready_mode == 0) begin
        bus.out_ready = 1'b1;
      end else begin
        bus.out_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  // Monitor: pops the owner's queue on every transfer, checks hold stability and done pulses
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset) begin
        hold_prev = 0;
      end else begin
        if (bus.out_valid) begin
          chk("no_start_while_valid", 64'(bus.smp_start), 64'd0);
          if (hold_prev) begin
            chk("hold_idx_stable", 64'(bus.out_idx), 64'(prev_idx));
            chk("hold_id_stable", 64'(bus.out_id), 64'(prev_id));
            chk_poly("hold_poly_stable", bus.out_poly, prev_poly);
          end
          if (bus.out_ready) begin
            hold_prev = 0;
            if ((bus.out_id == 1'b0 && q0.size() == 0) || (bus.out_id == 1'b1 && q1.size() == 0)) begin
              total++;
              bad++;
              $display("FAIL unexpected_poly actual id=%0d idx=%0d required none", bus.out_id, bus.out_idx);
            end else begin
              if (bus.out_id == 1'b0) e = q0.pop_front();
              else                    e = q1.pop_front();
              chk("out_idx", 64'(bus.out_idx), 64'(e.idx));
              chk_poly("out_poly", bus.out_poly, e.poly);
              got_first[bus.out_id] = 1;
            end
          end else begin
            hold_prev = 1;
            prev_poly = bus.out_poly;
            prev_idx  = bus.out_idx;
            prev_id   = bus.out_id;
          end
        end else begin
          hold_prev = 0;
        end
        for (int r = 0; r < 2; r++) begin
          if (bus.req_done[r]) begin
            total++;
            if (runs_pend[r] == 0 || (r == 0 && q0.size() != 0) || (r == 1 && q1.size() != 0)) begin
              bad++;
              $display("FAIL req_done_%0d actual=pulse pending=%0d left=%0d required=run complete",
                       r, runs_pend[r], (r == 0) ? q0.size() : q1.size());
            end else begin
              runs_pend[r]--;
            end
            done_order.push_back(r);
            got_first[r] = 0;
          end
        end
      end
    end
  end

  // Stimulus thread
  initial begin : stimulus
    int n;
    int r;
    int oth;
    int start_snap;
    bus.req_valid = 2'b00;
    bus.req_seed  = '0;
    bus.req_nonce = '0;
    bus.req_count = '0;
    runs_pend[0] = 0;
    runs_pend[1] = 0;

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_smp_start", 64'(bus.smp_start), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_req_done", 64'(bus.req_done), 64'd0);
    chk("rst_out_idx", 64'(bus.out_idx), 64'd0);
    do_reset();
    tick();

    // single run of five, start latency of three cycles
    smp_lat = 20;
    ready_mode = 0;
    nonce_log.delete();
    issue(0, rand512(), 16'h0000, 4'd5);
    n = 0;
    while (!bus.smp_start && n < 10) begin
      tick();
      n++;
    end
    chk("start_latency", 64'(n), 64'd3);
    wait_idle(1000, "t1");
    chk("t1_nonce_count", 64'(nonce_log.size()), 64'd5);
    for (int i = 0; i < nonce_log.size() && i < 5; i++) chk("t1_nonce", 64'(nonce_log[i]), 64'(i));

    // simultaneous requests: pointer 0 first, then the second tie favours 1
    do_reset();
    tick();
    smp_lat = 3;
    done_order.delete();
    issue(0, rand512(), 16'd0, 4'd5);
    issue(1, rand512(), 16'd5, 4'd6);
    wait_idle(2000, "t2a");
    chk("tie1_count", 64'(done_order.size()), 64'd2);
    if (done_order.size() == 2) begin
      chk("tie1_first", 64'(done_order[0]), 64'd0);
      chk("tie1_second", 64'(done_order[1]), 64'd1);
    end
    done_order.delete();
    issue(0, rand512(), 16'd20, 4'd2);
    issue(1, rand512(), 16'd40, 4'd3);
    wait_idle(2000, "t2b");
    chk("tie2_count", 64'(done_order.size()), 64'd2);
    if (done_order.size() == 2) begin
      chk("tie2_first", 64'(done_order[0]), 64'd1);
      chk("tie2_second", 64'(done_order[1]), 64'd0);
    end

    // consumer stalls 50 cycles on the first poly
    stall_arm = 1;
    issue(1, rand512(), 16'h1234, 4'd4);
    wait_idle(2000, "t3");

    // empty run: done two cycles after the request, sampler untouched
    start_snap = start_count;
    issue(1, rand512(), 16'h0042, 4'd0);
    n = 0;
    while (!bus.req_done[1] && n < 10) begin
      tick();
      n++;
    end
    chk("empty_done_latency", 64'(n), 64'd2);
    wait_idle(100, "t4");
    chk("empty_no_start", 64'(start_count), 64'(start_snap));

    // nonce wraps modulo 2**16
    nonce_log.delete();
    issue(0, rand512(), 16'hFFFE, 4'd3);
    wait_idle(1000, "t5");
    chk("wrap_count", 64'(nonce_log.size()), 64'd3);
    if (nonce_log.size() == 3) begin
      chk("wrap_n0", 64'(nonce_log[0]), 64'hFFFE);
      chk("wrap_n1", 64'(nonce_log[1]), 64'hFFFF);
      chk("wrap_n2", 64'(nonce_log[2]), 64'h0000);
    end

    // reset during the wait for poly 2 aborts the run
    smp_lat = 20;
    nonce_log.delete();
    done_order.delete();
    issue(0, rand512(), 16'd100, 4'd5);
    n = 0;
    while (nonce_log.size() < 3 && n < 500) begin
      tick();
      n++;
    end
    chk("t6_reached_poly2", 64'(nonce_log.size()), 64'd3);
    tick();
    tick();
    reset = 1'b1;
    #2;
    chk("t6_smp_start", 64'(bus.smp_start), 64'd0);
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_req_done", 64'(bus.req_done), 64'd0);
    chk("t6_out_idx", 64'(bus.out_idx), 64'd0);
    do_reset();
    chk("t6_no_done", 64'(done_order.size()), 64'd0);
    tick();
    issue(0, rand512(), 16'd7, 4'd2);
    wait_idle(1000, "t6");

    // randomized overlapping runs with random ready and latency
    ready_mode = 1;
    for (int it = 0; it < 25; it++) begin
      smp_lat = $urandom_range(0, 5);
      r = $urandom_range(0, 1);
      oth = 1 - r;
      issue(r, rand512(), 16'($urandom()), 4'($urandom_range(0, 6)));
      repeat ($urandom_range(0, 15)) tick();
      if (runs_pend[oth] == 0 && !bus.req_valid[oth]) begin
        issue(oth, rand512(), 16'($urandom()), 4'($urandom_range(0, 6)));
      end
      wait_idle(3000, "rand");
    end

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
